// File: rtl/arp_req_if.sv
// Signal bundle for the ARP request initiator: request control, decoded ARP
// replies from the receiver, the shared TX arbiter handshake and GMII transmit.
interface arp_req_if;
  logic        start;
  logic [31:0] des_ip;
  logic [31:0] board_ip;
  logic [47:0] board_mac;
  logic        arp_valid;
  logic [31:0] dec_ip;
  logic [47:0] dec_mac;
  logic        arp_tx_sel;
  logic        arp_tx_req;
  logic        arp_tx_done;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        busy;
  logic        resolved;
  logic [47:0] res_mac;
  logic        fail;

  modport master (
    output start, des_ip, board_ip, board_mac, arp_valid, dec_ip, dec_mac, arp_tx_sel,
    input  arp_tx_req, arp_tx_done, gmii_tx_en, gmii_txd, busy, resolved, res_mac, fail
  );

  modport slave (
    input  start, des_ip, board_ip, board_mac, arp_valid, dec_ip, dec_mac, arp_tx_sel,
    output arp_tx_req, arp_tx_done, gmii_tx_en, gmii_txd, busy, resolved, res_mac, fail
  );
endinterface

// File: rtl/arp_req.sv
// ARP request initiator: sends a broadcast ARP request with FCS on GMII,
// waits for the matching reply, retries on timeout and latches the resolved MAC.
module arp_req #(
  parameter int TIMEOUT_CYCLES = 125_000_000,
  parameter int MAX_RETRY      = 3,
  parameter int IFG_CYCLES     = 12
) (
  input  logic     gmii_tx_clk,
  input  logic     rst,
  arp_req_if.slave bus
);
  localparam int FRAME_LEN = 72;
  localparam int TMR_MAX   = (TIMEOUT_CYCLES > IFG_CYCLES) ? TIMEOUT_CYCLES : IFG_CYCLES;
  localparam int TW        = $clog2(TMR_MAX + 1);
  localparam int RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TMR_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_IFG     = TW'(IFG_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY);
  // EtherType, HTYPE, PTYPE, HLEN, PLEN, OPER as one big-endian constant
  localparam logic [79:0] ARP_FIXED = 80'h0806_0001_0800_0604_0001;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_SEND, S_IFG, S_WAIT} state_t;

  state_t        r_state, w_state_next;
  logic [6:0]    r_cnt;
  logic [TW-1:0] r_tmr;
  logic [RW-1:0] r_retry;
  logic [31:0]   r_des_ip;
  logic [31:0]   r_crc;
  logic [47:0]   r_res_mac;
  logic          r_resolved, r_matched, r_done, r_fail, r_tx_en;
  logic [7:0]    r_txd;
  logic [7:0]    w_frame [FRAME_LEN];
  logic [31:0]   w_fcs;
  logic          w_match, w_timeout, w_last;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int k = 0; k < 8; k++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  assign w_fcs = ~r_crc;

  genvar gi;
  generate
    for (gi = 0; gi < FRAME_LEN; gi++) begin : g_frame
      if (gi < 7) begin : g_pre
        assign w_frame[gi] = 8'h55;
      end else if (gi == 7) begin : g_sfd
        assign w_frame[gi] = 8'hD5;
      end else if (gi < 14) begin : g_bcast
        assign w_frame[gi] = 8'hFF;
      end else if (gi < 20) begin : g_src
        assign w_frame[gi] = bus.board_mac[8*(19-gi) +: 8];
      end else if (gi < 30) begin : g_fixed
        assign w_frame[gi] = ARP_FIXED[8*(29-gi) +: 8];
      end else if (gi < 36) begin : g_sha
        assign w_frame[gi] = bus.board_mac[8*(35-gi) +: 8];
      end else if (gi < 40) begin : g_spa
        assign w_frame[gi] = bus.board_ip[8*(39-gi) +: 8];
      end else if (gi < 46) begin : g_tha
        assign w_frame[gi] = 8'h00;
      end else if (gi < 50) begin : g_tpa
        assign w_frame[gi] = r_des_ip[8*(49-gi) +: 8];
      end else if (gi < 68) begin : g_pad
        assign w_frame[gi] = 8'h00;
      end else begin : g_fcs
        assign w_frame[gi] = w_fcs[8*(gi-68) +: 8];
      end
    end
  endgenerate

  assign w_last    = (r_cnt == 7'(FRAME_LEN));
  assign w_timeout = (r_state == S_WAIT) && (r_tmr == TMR_TIMEOUT);
  assign w_match   = bus.arp_valid && (bus.dec_ip == r_des_ip) &&
                     ((r_state == S_SEND) || (r_state == S_IFG) || (r_state == S_WAIT));

  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_state_next = S_REQ;
      S_REQ:  if (bus.arp_tx_sel) w_state_next = S_SEND;
      S_SEND: if (w_last) w_state_next = S_IFG;
      S_IFG: begin
        if (w_match)               w_state_next = S_IDLE;
        else if (r_tmr == TMR_IFG) w_state_next = r_matched ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (w_match)        w_state_next = S_IDLE;
        else if (w_timeout) w_state_next = (r_retry < RETRY_LAST) ? S_REQ : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_tmr      <= '0;
      r_retry    <= '0;
      r_des_ip   <= '0;
      r_crc      <= '1;
      r_res_mac  <= '0;
      r_resolved <= 1'b0;
      r_matched  <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      r_tx_en    <= 1'b0;
      r_txd      <= 8'h00;
    end else begin
      r_done <= 1'b0;
      r_fail <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_des_ip   <= bus.des_ip;
          r_resolved <= 1'b0;
          r_matched  <= 1'b0;
          r_retry    <= '0;
        end
        S_REQ: if (bus.arp_tx_sel) begin
          r_tx_en <= 1'b1;
          r_txd   <= w_frame[0];
          r_cnt   <= 7'd1;
          r_crc   <= '1;
        end
        S_SEND: begin
          if (w_last) begin
            r_tx_en <= 1'b0;
            r_txd   <= 8'h00;
            r_done  <= 1'b1;
          end else begin
            r_txd <= w_frame[r_cnt];
            r_cnt <= r_cnt + 7'd1;
            // FCS covers destination MAC through pad only
            if (r_cnt >= 7'd8 && r_cnt < 7'd68)
              r_crc <= crc32_byte(r_crc, w_frame[r_cnt]);
          end
        end
        S_WAIT: if (w_timeout && !w_match) begin
          if (r_retry < RETRY_LAST) r_retry <= r_retry + RW'(1);
          else                      r_fail  <= 1'b1;
        end
        default: ;
      endcase

      if (w_match) begin
        r_res_mac  <= bus.dec_mac;
        r_resolved <= 1'b1;
        if (r_state == S_SEND) r_matched <= 1'b1;
      end

      // Shared timer for IFG and reply timeout, restarted on every state change
      if (((r_state == S_IFG) || (r_state == S_WAIT)) && (w_state_next == r_state))
        r_tmr <= r_tmr + TW'(1);
      else
        r_tmr <= '0;
    end
  end

  assign bus.arp_tx_req  = (r_state == S_REQ) || (r_state == S_SEND);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.arp_tx_done = r_done;
  assign bus.gmii_tx_en  = r_tx_en;
  assign bus.gmii_txd    = r_txd;
  assign bus.resolved    = r_resolved;
  assign bus.res_mac     = r_res_mac;
  assign bus.fail        = r_fail;
endmodule

// File: tb/tb_arp_req.sv
// Bench for arp_req: random addresses and reply timing checked against a
// frame/timing model computed directly from the ARP frame layout and state rules.
module tb_arp_req;
  localparam int TO  = 100;
  localparam int MR  = 2;
  localparam int IFG = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arp_req_if u_if();

  arp_req #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR), .IFG_CYCLES(IFG)) dut (
    .gmii_tx_clk(clk),
    .rst        (rst),
    .bus        (u_if)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [7:0]  exp_f [72];
  logic [31:0] crc_tab [256];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [47:0] rand_mac();
    return {16'($urandom), $urandom} | 48'h1;
  endfunction

  // Table-driven zlib CRC32
  task automatic init_crc_tab();
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++)
        c = c[0] ? (32'hEDB88320 ^ (c >> 1)) : (c >> 1);
      crc_tab[n] = c;
    end
  endtask

  task automatic make_frame(input logic [47:0] mac, input logic [31:0] ip, input logic [31:0] dip);
    logic [7:0]  q[$];
    logic [31:0] c;
    logic [7:0]  fixed [10];
    fixed = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
    for (int i = 0; i < 7; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) q.push_back(8'hFF);
    for (int i = 5; i >= 0; i--) q.push_back(8'(mac >> (8*i)));
    for (int i = 0; i < 10; i++) q.push_back(fixed[i]);
    for (int i = 5; i >= 0; i--) q.push_back(8'(mac >> (8*i)));
    for (int i = 3; i >= 0; i--) q.push_back(8'(ip >> (8*i)));
    for (int i = 0; i < 6; i++) q.push_back(8'h00);
    for (int i = 3; i >= 0; i--) q.push_back(8'(dip >> (8*i)));
    for (int i = 0; i < 18; i++) q.push_back(8'h00);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < 68; i++) c = crc_tab[c[7:0] ^ q[i]] ^ (c >> 8);
    c = ~c;
    for (int i = 0; i < 4; i++) q.push_back(8'(c >> (8*i)));
    for (int i = 0; i < 72; i++) exp_f[i] = q[i];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_vec++;
    if ({u_if.arp_tx_req, u_if.arp_tx_done, u_if.gmii_tx_en, u_if.busy, u_if.resolved, u_if.fail} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got req/done/en/busy/res/fail=%b want 000000",
               {u_if.arp_tx_req, u_if.arp_tx_done, u_if.gmii_tx_en, u_if.busy, u_if.resolved, u_if.fail});
    end
    n_vec++;
    if (u_if.gmii_txd !== 8'h00 || u_if.res_mac !== 48'h0) begin
      n_err++;
      $display("FAIL reset_data: got txd=%02h res_mac=%012h want 00/0", u_if.gmii_txd, u_if.res_mac);
    end
    rst = 1'b0;
    repeat (4) tick();
    n_vec++;
    if (u_if.busy !== 1'b0 || u_if.arp_tx_req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b req=%b want 0/0", u_if.busy, u_if.arp_tx_req);
    end
  endtask

  task automatic test_basic();
    int g;
    logic [31:0] dip = 32'hC0A80166;
    u_if.board_mac  = 48'h000A3501FEC0;
    u_if.board_ip   = 32'hC0A8010A;
    u_if.arp_tx_sel = 1'b1;
    make_frame(u_if.board_mac, u_if.board_ip, dip);
    u_if.des_ip = dip;
    u_if.start  = 1'b1;
    g = cyc + 1;
    tick();
    u_if.start = 1'b0;
    n_vec++;
    if (u_if.busy !== 1'b1 || u_if.arp_tx_req !== 1'b1) begin
      n_err++;
      $display("FAIL basic_accept: got busy=%b req=%b want 1/1", u_if.busy, u_if.arp_tx_req);
    end
    for (int i = 0; i < 72; i++) begin
      tick();
      n_vec++;
      if (u_if.gmii_tx_en !== 1'b1 || u_if.gmii_txd !== exp_f[i]) begin
        n_err++;
        $display("FAIL basic_byte[%0d]: got en=%b txd=%02h want en=1 txd=%02h", i, u_if.gmii_tx_en, u_if.gmii_txd, exp_f[i]);
      end
    end
    tick();
    n_vec++;
    if ({u_if.arp_tx_done, u_if.arp_tx_req, u_if.gmii_tx_en} !== 3'b100) begin
      n_err++;
      $display("FAIL basic_done: got done/req/en=%b want 100 at G+73", {u_if.arp_tx_done, u_if.arp_tx_req, u_if.gmii_tx_en});
    end
    tick();
    n_vec++;
    if (u_if.arp_tx_done !== 1'b0 || u_if.busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b want 0/1", u_if.arp_tx_done, u_if.busy);
    end
    while (cyc < g + 73 + IFG + 5) tick();
    u_if.arp_valid = 1'b1;
    u_if.dec_ip    = dip;
    u_if.dec_mac   = 48'h112233445566;
    tick();
    u_if.arp_valid = 1'b0;
    n_vec++;
    if (u_if.resolved !== 1'b1 || u_if.res_mac !== 48'h112233445566 || u_if.busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_resolve: got resolved=%b res_mac=%012h busy=%b want 1/112233445566/0",
               u_if.resolved, u_if.res_mac, u_if.busy);
    end
  endtask

  task automatic test_match_in_send();
    int g, n_en;
    logic [31:0] dip = $urandom;
    logic [47:0] m   = rand_mac();
    u_if.board_mac = rand_mac();
    u_if.board_ip  = $urandom;
    make_frame(u_if.board_mac, u_if.board_ip, dip);
    u_if.des_ip = dip;
    u_if.start  = 1'b1;
    g = cyc + 1;
    tick();
    u_if.start = 1'b0;
    n_vec++;
    if (u_if.resolved !== 1'b0 || u_if.busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_clear: got resolved=%b busy=%b want 0/1", u_if.resolved, u_if.busy);
    end
    for (int i = 0; i < 72; i++) begin
      tick();
      n_vec++;
      if (u_if.gmii_tx_en !== 1'b1 || u_if.gmii_txd !== exp_f[i]) begin
        n_err++;
        $display("FAIL b2b_byte[%0d]: got en=%b txd=%02h want en=1 txd=%02h", i, u_if.gmii_tx_en, u_if.gmii_txd, exp_f[i]);
      end
      if (i == 39) begin
        u_if.arp_valid = 1'b1;
        u_if.dec_ip    = dip;
        u_if.dec_mac   = m;
      end
      if (i == 40) begin
        u_if.arp_valid = 1'b0;
        n_vec++;
        if (u_if.resolved !== 1'b1 || u_if.res_mac !== m || u_if.busy !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_send_match: got resolved=%b res_mac=%012h busy=%b want 1/%012h/1",
                   u_if.resolved, u_if.res_mac, u_if.busy, m);
        end
      end
    end
    tick();
    n_vec++;
    if (u_if.arp_tx_done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_done: got done=%b want 1", u_if.arp_tx_done);
    end
    while (cyc < g + 72 + IFG) tick();
    n_vec++;
    if (u_if.busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ifg_busy: got busy=%b want 1 during IFG", u_if.busy);
    end
    tick();
    n_vec++;
    if (u_if.busy !== 1'b0 || u_if.resolved !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_idle: got busy=%b resolved=%b want 0/1 after IFG", u_if.busy, u_if.resolved);
    end
    n_en = 0;
    repeat (150) begin
      tick();
      if (u_if.gmii_tx_en === 1'b1) n_en++;
    end
    n_vec++;
    if (n_en != 0) begin
      n_err++;
      $display("FAIL b2b_no_retry: got %0d tx cycles want 0", n_en);
    end
  endtask

  task automatic test_grant_delay();
    int g, w, r;
    logic [31:0] dip   = $urandom;
    logic [31:0] other = dip ^ 32'h00FF0001;
    logic [47:0] m     = rand_mac();
    u_if.arp_tx_sel = 1'b0;
    u_if.board_mac  = rand_mac();
    u_if.board_ip   = $urandom;
    make_frame(u_if.board_mac, u_if.board_ip, dip);
    u_if.des_ip = dip;
    u_if.start  = 1'b1;
    tick();
    u_if.start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      n_vec++;
      if (u_if.arp_tx_req !== 1'b1 || u_if.gmii_tx_en !== 1'b0) begin
        n_err++;
        $display("FAIL grant_wait[%0d]: got req=%b en=%b want 1/0", k, u_if.arp_tx_req, u_if.gmii_tx_en);
      end
      tick();
    end
    u_if.arp_tx_sel = 1'b1;
    g = cyc;
    for (int i = 0; i < 72; i++) begin
      tick();
      n_vec++;
      if (u_if.gmii_tx_en !== 1'b1 || u_if.gmii_txd !== exp_f[i]) begin
        n_err++;
        $display("FAIL grant_byte[%0d]: got en=%b txd=%02h want en=1 txd=%02h", i, u_if.gmii_tx_en, u_if.gmii_txd, exp_f[i]);
      end
      if (i == 10) u_if.arp_tx_sel = 1'b0;
      if (i == 20) begin
        u_if.des_ip = other;
        u_if.start  = 1'b1;
      end
      if (i == 21) u_if.start = 1'b0;
    end
    tick();
    n_vec++;
    if (u_if.arp_tx_done !== 1'b1 || u_if.gmii_tx_en !== 1'b0) begin
      n_err++;
      $display("FAIL grant_done: got done=%b en=%b want 1/0", u_if.arp_tx_done, u_if.gmii_tx_en);
    end
    w = g + 73 + IFG;
    while (cyc < w + 2) tick();
    u_if.arp_valid = 1'b1;
    u_if.dec_ip    = other;
    u_if.dec_mac   = rand_mac();
    tick();
    u_if.arp_valid = 1'b0;
    n_vec++;
    if (u_if.resolved !== 1'b0 || u_if.busy !== 1'b1) begin
      n_err++;
      $display("FAIL grant_ignore_reply: got resolved=%b busy=%b want 0/1", u_if.resolved, u_if.busy);
    end
    r = $urandom_range(5, TO - 2);
    while (cyc < w + r) tick();
    u_if.arp_valid = 1'b1;
    u_if.dec_ip    = dip;
    u_if.dec_mac   = m;
    tick();
    u_if.arp_valid  = 1'b0;
    u_if.arp_tx_sel = 1'b1;
    n_vec++;
    if (u_if.resolved !== 1'b1 || u_if.res_mac !== m || u_if.busy !== 1'b0) begin
      n_err++;
      $display("FAIL grant_resolve: got resolved=%b res_mac=%012h busy=%b want 1/%012h/0",
               u_if.resolved, u_if.res_mac, u_if.busy, m);
    end
  endtask

  task automatic test_match_at_timeout();
    int g, w, n_en, n_fail;
    logic [31:0] dip = $urandom;
    logic [47:0] m   = rand_mac();
    u_if.des_ip = dip;
    u_if.start  = 1'b1;
    g = cyc + 1;
    tick();
    u_if.start = 1'b0;
    w = g + 73 + IFG;
    while (cyc < w + TO - 1) tick();
    u_if.arp_valid = 1'b1;
    u_if.dec_ip    = dip;
    u_if.dec_mac   = m;
    tick();
    u_if.arp_valid = 1'b0;
    n_vec++;
    if (u_if.resolved !== 1'b1 || u_if.res_mac !== m || u_if.fail !== 1'b0 ||
        u_if.busy !== 1'b0 || u_if.arp_tx_req !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_match: got resolved=%b res_mac=%012h fail=%b busy=%b req=%b want 1/%012h/0/0/0",
               u_if.resolved, u_if.res_mac, u_if.fail, u_if.busy, u_if.arp_tx_req, m);
    end
    n_en = 0;
    n_fail = 0;
    repeat (250) begin
      tick();
      if (u_if.gmii_tx_en === 1'b1) n_en++;
      if (u_if.fail === 1'b1) n_fail++;
    end
    n_vec++;
    if (n_en != 0 || n_fail != 0) begin
      n_err++;
      $display("FAIL tmo_quiet: got tx_cycles=%0d fails=%0d want 0/0", n_en, n_fail);
    end
  endtask

  task automatic test_retry();
    int g, w, fail_exp, fail_at, n_fail, end_cyc;
    int starts[$];
    int exp_starts[3];
    logic prev_en;
    logic [31:0] dip = 32'hC0A80166;
    u_if.board_mac  = 48'h000A3501FEC0;
    u_if.board_ip   = 32'hC0A8010A;
    u_if.arp_tx_sel = 1'b1;
    u_if.des_ip = dip;
    u_if.start  = 1'b1;
    g = cyc + 1;
    tick();
    u_if.start = 1'b0;
    for (int k = 0; k <= MR; k++) begin
      exp_starts[k] = g + 1;
      w = g + 73 + IFG;
      g = w + TO;
    end
    fail_exp = g;
    end_cyc  = fail_exp + 150;
    prev_en  = 1'b0;
    n_fail   = 0;
    fail_at  = -1;
    while (cyc < end_cyc) begin
      u_if.arp_valid = ($urandom_range(0, 7) == 0);
      u_if.dec_ip    = 32'hC0A80163;
      u_if.dec_mac   = rand_mac();
      tick();
      if (u_if.gmii_tx_en === 1'b1 && !prev_en) starts.push_back(cyc);
      prev_en = u_if.gmii_tx_en;
      if (u_if.fail === 1'b1) begin
        n_fail++;
        fail_at = cyc;
      end
    end
    u_if.arp_valid = 1'b0;
    n_vec++;
    if (starts.size() != MR + 1) begin
      n_err++;
      $display("FAIL retry_frames: got %0d frames want %0d", starts.size(), MR + 1);
    end
    for (int k = 0; k <= MR; k++) begin
      if (k < starts.size()) begin
        n_vec++;
        if (starts[k] != exp_starts[k]) begin
          n_err++;
          $display("FAIL retry_start[%0d]: got cycle %0d want %0d", k, starts[k], exp_starts[k]);
        end
      end
    end
    n_vec++;
    if (n_fail != 1 || fail_at != fail_exp) begin
      n_err++;
      $display("FAIL retry_fail: got %0d pulses last at %0d want 1 at %0d", n_fail, fail_at, fail_exp);
    end
    n_vec++;
    if (u_if.resolved !== 1'b0 || u_if.busy !== 1'b0) begin
      n_err++;
      $display("FAIL retry_end: got resolved=%b busy=%b want 0/0", u_if.resolved, u_if.busy);
    end
  endtask

  task automatic test_rst_mid_frame();
    int g, n_act;
    logic [31:0] dip = $urandom;
    u_if.board_mac  = rand_mac();
    u_if.board_ip   = $urandom;
    u_if.arp_tx_sel = 1'b1;
    make_frame(u_if.board_mac, u_if.board_ip, dip);
    u_if.des_ip = dip;
    u_if.start  = 1'b1;
    g = cyc + 1;
    tick();
    u_if.start = 1'b0;
    while (cyc < g + 31) tick();
    n_vec++;
    if (u_if.gmii_tx_en !== 1'b1 || u_if.gmii_txd !== exp_f[30]) begin
      n_err++;
      $display("FAIL rst_pre_byte30: got en=%b txd=%02h want 1/%02h", u_if.gmii_tx_en, u_if.gmii_txd, exp_f[30]);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (u_if.gmii_tx_en !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async_en: got en=%b want 0 before next edge", u_if.gmii_tx_en);
    end
    n_vec++;
    if ({u_if.arp_tx_req, u_if.arp_tx_done, u_if.busy, u_if.resolved, u_if.fail} !== 5'b0 ||
        u_if.gmii_txd !== 8'h00 || u_if.res_mac !== 48'h0) begin
      n_err++;
      $display("FAIL rst_outputs: got req/done/busy/res/fail=%b txd=%02h res_mac=%012h want 0/00/0",
               {u_if.arp_tx_req, u_if.arp_tx_done, u_if.busy, u_if.resolved, u_if.fail}, u_if.gmii_txd, u_if.res_mac);
    end
    tick();
    tick();
    rst = 1'b0;
    n_act = 0;
    repeat (100) begin
      tick();
      if (u_if.gmii_tx_en === 1'b1 || u_if.busy === 1'b1 || u_if.arp_tx_req === 1'b1) n_act++;
    end
    n_vec++;
    if (n_act != 0) begin
      n_err++;
      $display("FAIL rst_restart_idle: got %0d active cycles want 0", n_act);
    end
  endtask

  initial begin
    u_if.start      = 1'b0;
    u_if.des_ip     = '0;
    u_if.board_ip   = '0;
    u_if.board_mac  = '0;
    u_if.arp_valid  = 1'b0;
    u_if.dec_ip     = '0;
    u_if.dec_mac    = '0;
    u_if.arp_tx_sel = 1'b0;
    init_crc_tab();
    test_reset();
    test_basic();
    test_match_in_send();
    test_grant_delay();
    test_match_at_timeout();
    test_retry();
    test_rst_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
